// File: rtl/pu_spi_reader_pkg.sv
// Shared types and constants for the PU result reader: fetch FSM encoding,
// default frame geometry and the CRC-8 step used when PU_SPI_READER_CRC8_EN is set.
package pu_spi_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OE_Q,
    ST_CAP_Q,
    ST_OE_R,
    ST_CAP_R
  } fetch_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ATTR_WIDTH_DEF = 4;
  localparam int FRAME_WIDTH    = 2 * (ATTR_WIDTH_DEF + DATA_WIDTH_DEF);

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first CRC-8 shift with the message bit folded into the feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return fb ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/pu_spi_reader_spi_slave_tx.sv
// Mode-0 SPI slave transmitter: synchronises the master's pins, loads the frame
// on CS fall and shifts it out MSB first on each SCLK fall, then drives zeros.
module spi_slave_tx
  import pu_spi_reader_pkg::*;
#(
  parameter int WIDTH = FRAME_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] frame_i,
  input  logic             sclk_i,
  input  logic             cs_i,
  input  logic             mosi_i,
  output logic             miso_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [1:0]       sclk_sync_q;
  logic [1:0]       cs_sync_q;
  logic             mosi_meta_q;
  logic             mosi_unused_q;
  logic             sclk_prev_q;
  logic             cs_prev_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             miso_q;

  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_fall = sclk_prev_q & ~sclk_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_sync_q[1];
  assign cs_rise   = ~cs_prev_q & cs_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q   <= 2'b00;
      cs_sync_q     <= 2'b11;
      mosi_meta_q   <= 1'b0;
      mosi_unused_q <= 1'b0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[0], sclk_i};
      cs_sync_q     <= {cs_sync_q[0], cs_i};
      mosi_meta_q   <= mosi_i;
      mosi_unused_q <= mosi_meta_q;
      sclk_prev_q   <= sclk_sync_q[1];
      cs_prev_q     <= cs_sync_q[1];
    end
  end

  // cnt_q counts bits already presented on miso; once it reaches WIDTH the line stays low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
    end else if (cs_fall) begin
      shreg_q <= frame_i;
      cnt_q   <= CW'(1);
      miso_q  <= frame_i[WIDTH-1];
    end else if (cs_rise) begin
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else if (!cs_sync_q[1] && sclk_fall) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
      if (cnt_q < WIDTH_C) begin
        cnt_q  <= cnt_q + CW'(1);
        miso_q <= shreg_q[WIDTH-2];
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign miso_o = miso_q;

endmodule

// File: rtl/pu_spi_reader.sv
// Fetches the PU quotient and remainder into a shadow frame for an external SPI master.
// Define PU_SPI_READER_CRC8_EN to append a CRC-8 byte to the frame.
module pu_spi_reader
  import pu_spi_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ATTR_WIDTH = ATTR_WIDTH_DEF,
  parameter int INVALID    = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  snap,
  input  logic [DATA_WIDTH-1:0] pu_data_out,
  input  logic [ATTR_WIDTH-1:0] pu_attr_out,
  output logic                  signal_oe,
  output logic                  res_select,
  output logic                  busy,
  output logic                  frame_valid,
  output logic                  invalid_seen,
  input  logic                  ext_slave_sclk,
  input  logic                  ext_slave_cs,
  input  logic                  ext_slave_mosi,
  output logic                  ext_slave_miso
);

  localparam int HALF = ATTR_WIDTH + DATA_WIDTH;
  localparam int F    = 2 * HALF;
`ifdef PU_SPI_READER_CRC8_EN
  localparam int TX_WIDTH = F + 8;
`else
  localparam int TX_WIDTH = F;
`endif

  fetch_state_e   state_q;
  logic           oe_q;
  logic           sel_q;
  logic           busy_q;
  logic           valid_q;
  logic           invalid_q;
  logic [F-1:0]   shadow_q;
  logic [TX_WIDTH-1:0] tx_frame;

`ifdef PU_SPI_READER_CRC8_EN
  logic [7:0]   crc_q;
  logic [7:0]   crc_next;
  logic [F-1:0] crc_frame;

  // CRC over the complete frame as it will exist after the CAP_R capture.
  always_comb begin
    crc_next  = '0;
    crc_frame = {shadow_q[F-1:HALF], pu_attr_out, pu_data_out};
    for (int i = F - 1; i >= 0; i--) begin
      crc_next = crc8_step(crc_next, crc_frame[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      crc_q <= '0;
    end else if (state_q == ST_CAP_R) begin
      crc_q <= crc_next;
    end
  end

  assign tx_frame = {shadow_q, crc_q};
`else
  assign tx_frame = shadow_q;
`endif

  // The PU answers one clk after oe/select change, so each CAP state samples the bus.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      oe_q      <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      shadow_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (snap) begin
            state_q   <= ST_OE_Q;
            oe_q      <= 1'b1;
            sel_q     <= 1'b0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
          end
        end
        ST_OE_Q: state_q <= ST_CAP_Q;
        ST_CAP_Q: begin
          state_q             <= ST_OE_R;
          sel_q               <= 1'b1;
          shadow_q[F-1:HALF]  <= {pu_attr_out, pu_data_out};
          if (pu_attr_out[INVALID]) invalid_q <= 1'b1;
        end
        ST_OE_R: state_q <= ST_CAP_R;
        ST_CAP_R: begin
          state_q            <= ST_IDLE;
          oe_q               <= 1'b0;
          sel_q              <= 1'b0;
          busy_q             <= 1'b0;
          valid_q            <= 1'b1;
          shadow_q[HALF-1:0] <= {pu_attr_out, pu_data_out};
          if (pu_attr_out[INVALID]) invalid_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign signal_oe    = oe_q;
  assign res_select   = sel_q;
  assign busy         = busy_q;
  assign frame_valid  = valid_q;
  assign invalid_seen = invalid_q;

  spi_slave_tx #(
    .WIDTH(TX_WIDTH)
  ) u_spi_tx (
    .clk_i  (clk),
    .rst_i  (RST),
    .frame_i(tx_frame),
    .sclk_i (ext_slave_sclk),
    .cs_i   (ext_slave_cs),
    .mosi_i (ext_slave_mosi),
    .miso_o (ext_slave_miso)
  );

endmodule
